// File: rtl/seg7_to_bin_pkg.sv
// ============================================================================
//  Module      : seg7_to_bin_pkg
//  Description : Shared FSM state encoding and 7-segment pattern constants
//                for the two-digit segment-to-binary converter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_to_bin_pkg;

    typedef enum logic [1:0] {
        ST_TENS  = 2'd0,
        ST_UNITS = 2'd1,
        ST_CALC  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_SEG_0     = 7'b1000000;
    localparam logic [6:0] c_SEG_1     = 7'b1111001;
    localparam logic [6:0] c_SEG_2     = 7'b0100100;
    localparam logic [6:0] c_SEG_3     = 7'b0110000;
    localparam logic [6:0] c_SEG_4     = 7'b0011001;
    localparam logic [6:0] c_SEG_5     = 7'b0010010;
    localparam logic [6:0] c_SEG_6     = 7'b0000010;
    localparam logic [6:0] c_SEG_7     = 7'b1111000;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0010000;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/seg7_dec.sv
// ============================================================================
//  Module      : seg7_dec
//  Description : Combinational active-low 7-segment pattern to BCD digit
//                decoder with pattern-valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_dec
    import seg7_to_bin_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_digit,
    output logic       o_valid
);

    always_comb begin
        o_digit = 4'd0;
        o_valid = 1'b1;
        case (i_pattern)
            c_SEG_0: o_digit = 4'd0;
            c_SEG_1: o_digit = 4'd1;
            c_SEG_2: o_digit = 4'd2;
            c_SEG_3: o_digit = 4'd3;
            c_SEG_4: o_digit = 4'd4;
            c_SEG_5: o_digit = 4'd5;
            c_SEG_6: o_digit = 4'd6;
            c_SEG_7: o_digit = 4'd7;
            c_SEG_8: o_digit = 4'd8;
            c_SEG_9: o_digit = 4'd9;
            default: o_valid = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_to_bin.sv
// ============================================================================
//  Module      : seg7_to_bin
//  Description : Collects a tens and a units 7-segment digit, converts the
//                frame to binary (0..99) and BCD, with error pulse/counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_to_bin
    import seg7_to_bin_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       seg_pos,
    input  logic       seg_valid,
    output logic       seg_ready,
    output logic [6:0] bin_out,
    output logic [7:0] bcd_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic [7:0] err_cnt
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_tens;
    logic [3:0] r_units;
    logic [6:0] r_bin;
    logic [7:0] r_bcd;
    logic       r_err;
    logic [7:0] r_err_cnt;

    logic [6:0] w_pattern;
    logic [3:0] w_digit;
    logic       w_digit_valid;
    logic       w_xfer;
    logic       w_latch_tens;
    logic       w_latch_units;
    logic       w_reject;
    logic       w_calc;
    logic [6:0] w_tens7;
    logic [6:0] w_bin_calc;

    // Active-high displays are normalised to active-low before decoding
    assign w_pattern = (SEG_ACTIVE_LOW != 0) ? seg_in : ~seg_in;

    seg7_dec u_dec (
        .i_pattern (w_pattern),
        .o_digit   (w_digit),
        .o_valid   (w_digit_valid)
    );

    assign seg_ready = (r_state == ST_TENS) || (r_state == ST_UNITS);
    assign w_xfer    = seg_valid && seg_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_latch_tens  = 1'b0;
        w_latch_units = 1'b0;
        w_reject      = 1'b0;
        w_calc        = 1'b0;
        case (r_state)
            ST_TENS: begin
                if (w_xfer) begin
                    if (!w_digit_valid || !seg_pos) begin
                        w_reject = 1'b1;
                    end else begin
                        w_latch_tens = 1'b1;
                        w_state_nxt  = ST_UNITS;
                    end
                end
            end
            ST_UNITS: begin
                if (w_xfer) begin
                    if (!w_digit_valid) begin
                        w_reject = 1'b1;
                    end else if (seg_pos) begin
                        // A second tens digit restarts the frame
                        w_latch_tens = 1'b1;
                        w_reject     = 1'b1;
                    end else begin
                        w_latch_units = 1'b1;
                        w_state_nxt   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                w_calc      = 1'b1;
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_state_nxt = ST_TENS;
                end
            end
            default: w_state_nxt = ST_TENS;
        endcase
    end

    // tens*10 as shift-and-add; 9*10+9 fits in 7 bits
    assign w_tens7    = {3'b000, r_tens};
    assign w_bin_calc = (w_tens7 << 3) + (w_tens7 << 1) + {3'b000, r_units};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_TENS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tens    <= 4'd0;
            r_units   <= 4'd0;
            r_bin     <= 7'd0;
            r_bcd     <= 8'd0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_err <= w_reject;
            if (w_latch_tens) begin
                r_tens <= w_digit;
            end
            if (w_latch_units) begin
                r_units <= w_digit;
            end
            if (w_calc) begin
                r_bin <= w_bin_calc;
                r_bcd <= {r_tens, r_units};
            end
            if (w_reject && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign bin_out   = r_bin;
    assign bcd_out   = r_bcd;
    assign out_valid = (r_state == ST_OUT);
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_seg7_to_bin.sv
// ============================================================================
//  Module      : tb_seg7_to_bin
//  Description : Directed self-checking bench for seg7_to_bin with a result
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_to_bin;
    import seg7_to_bin_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] seg_in = 7'd0;
    logic       seg_pos = 1'b0;
    logic       seg_valid = 1'b0;
    logic       seg_ready;
    logic [6:0] bin_out;
    logic [7:0] bcd_out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    logic [14:0] sb[$];

    seg7_to_bin #(.SEG_ACTIVE_LOW(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .seg_pos   (seg_pos),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .bin_out   (bin_out),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [6:0] b, input logic [7:0] d);
        sb.push_back({b, d});
    endtask

    // Called at #1 after a rising edge; returns at #1 after the transfer edge
    task automatic send(input logic [6:0] pat, input logic pos);
        int n;
        seg_in    = pat;
        seg_pos   = pos;
        seg_valid = 1'b1;
        n = 0;
        while (seg_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) chk("ready_timeout", {31'd0, seg_ready}, 32'd1);
        @(posedge clk); #1;
        seg_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) chk("out_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    // Scoreboard: a result transfer happens on the next rising edge
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                logic [14:0] e;
                e = sb.pop_front();
                chk("sb_bin", {25'd0, bin_out}, {25'd0, e[14:8]});
                chk("sb_bcd", {24'd0, bcd_out}, {24'd0, e[7:0]});
            end
        end
    end

    initial begin
        // Reset state
        rst = 1'b1;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_bin", {25'd0, bin_out}, 32'd0);
        chk("rst_bcd", {24'd0, bcd_out}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_seg_ready", {31'd0, seg_ready}, 32'd1);

        // 1,5 -> 15, latency and handshake timing
        send(c_SEG_1, 1'b1);
        send(c_SEG_5, 1'b0);
        push(7'd15, 8'h15);
        chk("calc_out_valid", {31'd0, out_valid}, 32'd0);
        chk("calc_seg_ready", {31'd0, seg_ready}, 32'd0);
        @(posedge clk); #1;
        chk("out_valid_lat2", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        chk("after_xfer_valid", {31'd0, out_valid}, 32'd0);
        chk("after_xfer_ready", {31'd0, seg_ready}, 32'd1);

        // 9,9 with backpressure; digits offered during ST_OUT are ignored
        out_ready = 1'b0;
        send(c_SEG_9, 1'b1);
        send(c_SEG_9, 1'b0);
        push(7'd99, 8'h99);
        @(posedge clk); #1;
        seg_in = c_SEG_3; seg_pos = 1'b0; seg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_bin", {25'd0, bin_out}, 32'd99);
            chk("hold_seg_ready", {31'd0, seg_ready}, 32'd0);
            chk("hold_err", {31'd0, err}, 32'd0);
            @(posedge clk); #1;
        end
        seg_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("accept_on_rise", {31'd0, out_valid}, 32'd0);
        chk("ignored_err_cnt", {24'd0, err_cnt}, 32'd0);

        // Units offered first
        send(c_SEG_3, 1'b0);
        chk("units_first_err", {31'd0, err}, 32'd1);
        chk("units_first_cnt", {24'd0, err_cnt}, 32'd1);
        chk("units_first_ready", {31'd0, seg_ready}, 32'd1);
        @(posedge clk); #1;
        chk("err_one_cycle", {31'd0, err}, 32'd0);

        // Frame restart: 2, 4, 0 -> 40
        send(c_SEG_2, 1'b1);
        chk("tens2_no_err", {31'd0, err}, 32'd0);
        send(c_SEG_4, 1'b1);
        chk("restart_err", {31'd0, err}, 32'd1);
        chk("restart_cnt", {24'd0, err_cnt}, 32'd2);
        send(c_SEG_0, 1'b0);
        push(7'd40, 8'h40);
        wait_out();
        @(posedge clk); #1;

        // Invalid tens pattern, then saturation
        send(c_SEG_BLANK, 1'b1);
        chk("blank_err", {31'd0, err}, 32'd1);
        chk("blank_cnt", {24'd0, err_cnt}, 32'd3);
        send(c_SEG_8, 1'b0);
        chk("still_tens_err", {31'd0, err}, 32'd1);
        chk("still_tens_cnt", {24'd0, err_cnt}, 32'd4);
        seg_in = c_SEG_BLANK; seg_pos = 1'b1; seg_valid = 1'b1;
        repeat (256) @(posedge clk);
        #1;
        chk("sat_cnt", {24'd0, err_cnt}, 32'd255);
        chk("sat_err", {31'd0, err}, 32'd1);
        seg_valid = 1'b0;
        @(posedge clk); #1;
        chk("sat_hold", {24'd0, err_cnt}, 32'd255);
        chk("sat_err_drop", {31'd0, err}, 32'd0);

        // Reset while in ST_UNITS
        send(c_SEG_5, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rstu_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstu_err_cnt", {24'd0, err_cnt}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        send(c_SEG_7, 1'b0);
        chk("rstu_to_tens_err", {31'd0, err}, 32'd1);
        chk("rstu_to_tens_cnt", {24'd0, err_cnt}, 32'd1);

        // Reset while in ST_OUT: pending result is dropped
        out_ready = 1'b0;
        send(c_SEG_3, 1'b1);
        send(c_SEG_3, 1'b0);
        wait_out();
        chk("pend_bin", {25'd0, bin_out}, 32'd33);
        #2 rst = 1'b1;
        #1;
        chk("rsto_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rsto_bin", {25'd0, bin_out}, 32'd0);
        chk("rsto_bcd", {24'd0, bcd_out}, 32'd0);
        @(negedge clk); rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Next full frame 0,7 -> 7
        send(c_SEG_0, 1'b1);
        send(c_SEG_7, 1'b0);
        push(7'd7, 8'h07);
        wait_out();
        @(posedge clk); #1;
        chk("final_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
